// File: rtl/ex_stage.sv
// EX stage of the 16-bit pipeline: operand forwarding mux, ALU and the EX/MEM register.
// Optional signed-overflow flag on mem_ovf is built only when EX_OVF_FLAG_EN is defined.
module ex_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   ex_opcode,
  input  logic [2:0]   ex_dest,
  input  logic [W-1:0] id_val1,
  input  logic [W-1:0] id_val2,
  input  logic [W-1:0] imm,
  input  logic [1:0]   ALUsel1,
  input  logic [1:0]   ALUsel2,
  input  logic [W-1:0] mem_fwd_data,
  input  logic [W-1:0] wb_fwd_data,
  input  logic         stall,
  input  logic         flush,
  output logic [3:0]   mem_opcode,
  output logic [2:0]   mem_reg,
  output logic         wb_mem,
  output logic [W-1:0] mem_alu_res,
  output logic [W-1:0] mem_store_data,
  output logic         mem_valid,
  output logic [W-1:0] stall_cnt,
  output logic         mem_ovf
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,
    OP_OR   = 4'd4,  OP_NOR = 4'd5,  OP_XOR = 4'd6,  OP_SLL = 4'd7,
    OP_SRL  = 4'd8,  OP_ADDI = 4'd9, OP_LD  = 4'd10, OP_ST  = 4'd11
  } opcode_e;

  typedef struct packed {
    logic [3:0]   opcode;
    logic [2:0]   dest;
    logic         wb;
    logic         valid;
    logic [W-1:0] alu_res;
    logic [W-1:0] store_data;
  } exmem_t;

  exmem_t       exmem_d, exmem_q;
  logic [W-1:0] stall_cnt_d, stall_cnt_q;
  logic [W-1:0] op_a, op_r, op_b, alu_res;
  logic         bubble;

  // Forwarding encoding: 1 = MEM result, 2 = WB result, 0/3 = register file.
  function automatic logic [W-1:0] fwd_sel(input logic [1:0] sel, input logic [W-1:0] rf,
                                           input logic [W-1:0] mem_v, input logic [W-1:0] wb_v);
    case (sel)
      2'd1:    return mem_v;
      2'd2:    return wb_v;
      default: return rf;
    endcase
  endfunction

  always_comb begin
    op_a = fwd_sel(ALUsel1, id_val1, mem_fwd_data, wb_fwd_data);
    op_r = fwd_sel(ALUsel2, id_val2, mem_fwd_data, wb_fwd_data);
    op_b = (ex_opcode inside {OP_ADDI, OP_LD, OP_ST}) ? imm : op_r;
  end

  always_comb begin
    alu_res = '0;
    case (ex_opcode)
      OP_ADD, OP_ADDI, OP_LD, OP_ST: alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << op_b[3:0];
      OP_SRL:  alu_res = op_a >> op_b[3:0];
      default: alu_res = '0;
    endcase
  end

  assign bubble = stall | flush;

  always_comb begin
    exmem_d = '0;
    if (!bubble) begin
      exmem_d.opcode     = ex_opcode;
      exmem_d.valid      = (ex_opcode >= 4'd1) && (ex_opcode <= 4'd11);
      exmem_d.wb         = (ex_opcode >= 4'd1) && (ex_opcode <= 4'd10);
      exmem_d.dest       = exmem_d.wb ? ex_dest : 3'd0;
      exmem_d.alu_res    = alu_res;
      exmem_d.store_data = op_r;
    end
  end

  // Saturating bubble counter; flush alone leaves it untouched.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      exmem_q     <= exmem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef EX_OVF_FLAG_EN
  logic ovf_d, ovf_q;

  // Signed overflow: add overflows when same-sign operands give a different-sign
  // result; subtract when the operands differ in sign and the result flips from A.
  always_comb begin
    ovf_d = 1'b0;
    if (!bubble) begin
      case (ex_opcode)
        OP_ADD, OP_ADDI:
          ovf_d = (op_a[W-1] == op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
        OP_SUB:
          ovf_d = (op_a[W-1] != op_b[W-1]) && (alu_res[W-1] != op_a[W-1]);
        default: ovf_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign mem_ovf = ovf_q;
`else
  assign mem_ovf = 1'b0;
`endif

  assign mem_opcode     = exmem_q.opcode;
  assign mem_reg        = exmem_q.dest;
  assign wb_mem         = exmem_q.wb;
  assign mem_valid      = exmem_q.valid;
  assign mem_alu_res    = exmem_q.alu_res;
  assign mem_store_data = exmem_q.store_data;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

`ifdef EX_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_dest;
  logic [15:0] id_val1, id_val2, imm, mem_fwd_data, wb_fwd_data;
  logic [1:0]  ALUsel1, ALUsel2;
  logic        stall, flush;
  logic [3:0]  mem_opcode;
  logic [2:0]  mem_reg;
  logic        wb_mem, mem_valid, mem_ovf;
  logic [15:0] mem_alu_res, mem_store_data, stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .ex_opcode(ex_opcode), .ex_dest(ex_dest),
    .id_val1(id_val1), .id_val2(id_val2), .imm(imm),
    .ALUsel1(ALUsel1), .ALUsel2(ALUsel2),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .stall(stall), .flush(flush),
    .mem_opcode(mem_opcode), .mem_reg(mem_reg), .wb_mem(wb_mem),
    .mem_alu_res(mem_alu_res), .mem_store_data(mem_store_data),
    .mem_valid(mem_valid), .stall_cnt(stall_cnt), .mem_ovf(mem_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] op, input logic [2:0] rg,
                         input logic wb, input logic [15:0] res, input logic [15:0] sd,
                         input logic vld);
    chk({tag, ".opcode"}, 32'(mem_opcode), 32'(op));
    chk({tag, ".reg"},    32'(mem_reg), 32'(rg));
    chk({tag, ".wb"},     32'(wb_mem), 32'(wb));
    chk({tag, ".res"},    32'(mem_alu_res), 32'(res));
    chk({tag, ".sd"},     32'(mem_store_data), 32'(sd));
    chk({tag, ".valid"},  32'(mem_valid), 32'(vld));
  endtask

  task automatic chk_bubble(input string tag);
    chk_out(tag, 4'd0, 3'd0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk({tag, ".ovf"}, 32'(mem_ovf), 32'd0);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] dest,
                       input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] im,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [15:0] mf, input logic [15:0] wf,
                       input logic st, input logic fl);
    ex_opcode = op; ex_dest = dest; id_val1 = v1; id_val2 = v2; imm = im;
    ALUsel1 = s1; ALUsel2 = s2; mem_fwd_data = mf; wb_fwd_data = wf;
    stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd1, 3'd1, 16'h1111, 16'h2222, 16'h3333, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    chk_bubble("reset_hold");
    chk("reset_hold.cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // First edge after reset is a normal load: forward from MEM.
    drive(4'd1, 3'd3, 16'h0005, 16'h0003, 16'h0, 2'd1, 2'd0, 16'h0010, 16'h0, 1'b0, 1'b0);
    step();
    chk_out("fwd_mem", 4'd1, 3'd3, 1'b1, 16'h0013, 16'h0003, 1'b1);
    chk("fwd_mem.ovf", 32'(mem_ovf), 32'd0);

    drive(4'd11, 3'd5, 16'h0100, 16'h1111, 16'h0004, 2'd0, 2'd2, 16'h2222, 16'hBEEF, 1'b0, 1'b0);
    step();
    chk_out("st_wbfwd", 4'd11, 3'd0, 1'b0, 16'h0104, 16'hBEEF, 1'b1);

    drive(4'd2, 3'd7, 16'h0005, 16'h0007, 16'h0, 2'd3, 2'd3, 16'h9999, 16'h8888, 1'b0, 1'b0);
    step();
    chk_out("sub_sel3", 4'd2, 3'd7, 1'b1, 16'hFFFE, 16'h0007, 1'b1);

    drive(4'd3, 3'd1, 16'hF0F0, 16'h1234, 16'h0, 2'd0, 2'd1, 16'hFF00, 16'h0, 1'b0, 1'b0);
    step();
    chk_out("and", 4'd3, 3'd1, 1'b1, 16'hF000, 16'hFF00, 1'b1);

    drive(4'd4, 3'd2, 16'hF0F0, 16'h0F01, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("or.res", 32'(mem_alu_res), 32'h0000FFF1);

    drive(4'd5, 3'd2, 16'hF0F0, 16'h0F00, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("nor.res", 32'(mem_alu_res), 32'h0000000F);

    drive(4'd6, 3'd2, 16'hAAAA, 16'hFFFF, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("xor.res", 32'(mem_alu_res), 32'h00005555);

    drive(4'd7, 3'd4, 16'h0001, 16'h0013, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk_out("sll", 4'd7, 3'd4, 1'b1, 16'h0008, 16'h0013, 1'b1);

    drive(4'd8, 3'd4, 16'h8000, 16'h0014, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("srl.res", 32'(mem_alu_res), 32'h00000800);

    drive(4'd10, 3'd2, 16'h1000, 16'h0055, 16'hFFFC, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk_out("ld", 4'd10, 3'd2, 1'b1, 16'h0FFC, 16'h0055, 1'b1);

    drive(4'd12, 3'd6, 16'h0005, 16'h0006, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk_out("op12", 4'd12, 3'd0, 1'b0, 16'h0000, 16'h0006, 1'b0);

    drive(4'd0, 3'd6, 16'h0005, 16'h0006, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk_out("op0", 4'd0, 3'd0, 1'b0, 16'h0000, 16'h0006, 1'b0);

    // Signed overflow cases.
    drive(4'd1, 3'd1, 16'h7FFF, 16'h0001, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("ovf_add.res", 32'(mem_alu_res), 32'h00008000);
    chk("ovf_add.ovf", 32'(mem_ovf), 32'(OVF_EN));

    drive(4'd2, 3'd1, 16'h8000, 16'h0001, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("ovf_sub.res", 32'(mem_alu_res), 32'h00007FFF);
    chk("ovf_sub.ovf", 32'(mem_ovf), 32'(OVF_EN));

    drive(4'd9, 3'd1, 16'h7FFF, 16'h0000, 16'h0001, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("ovf_addi.res", 32'(mem_alu_res), 32'h00008000);
    chk("ovf_addi.ovf", 32'(mem_ovf), 32'(OVF_EN));

    drive(4'd6, 3'd1, 16'h7FFF, 16'h8000, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("xor_noovf.ovf", 32'(mem_ovf), 32'd0);

    // Flush only: bubble, counter untouched.
    drive(4'd1, 3'd3, 16'h7FFF, 16'h0001, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    step();
    chk_bubble("flush");
    chk("flush.cnt", 32'(stall_cnt), 32'd0);

    // Three stall bubbles after a fresh reset.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(4'd1, 3'd3, 16'h7FFF, 16'h0001, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      chk_bubble($sformatf("stall%0d", i));
      chk($sformatf("stall%0d.cnt", i), 32'(stall_cnt), 32'(i));
    end

    // Asynchronous reset mid-cycle with valid data registered.
    drive(4'd1, 3'd3, 16'h0005, 16'h0003, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk_out("pre_arst", 4'd1, 3'd3, 1'b1, 16'h0008, 16'h0003, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_bubble("arst");
    chk("arst.cnt", 32'(stall_cnt), 32'd0);
    step();
    chk_bubble("arst_edge");
    rst = 1'b0;

    // Saturation: 65535 stalls reach 0xFFFF, then a normal load, then stall+flush.
    drive(4'd1, 3'd3, 16'h0005, 16'h0003, 16'h0, 2'd0, 2'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    repeat (65535) step();
    chk("sat.cnt", 32'(stall_cnt), 32'h0000FFFF);
    stall = 1'b0;
    step();
    chk_out("sat_load", 4'd1, 3'd3, 1'b1, 16'h0008, 16'h0003, 1'b1);
    chk("sat_load.cnt", 32'(stall_cnt), 32'h0000FFFF);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk_bubble("sat_flush");
    chk("sat_flush.cnt", 32'(stall_cnt), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
